rr_grant_encoder4: RTL and testbench

Four-requester round-robin arbiter with grant hold, release handshake and timeout. It produces the registered 2-bit index of the current grantee plus a valid flag. It sits directly upstream of `decoder2_4`: `gnt_idx` drives the decoder's `in`, and the decoder's `out`, qualified by `gnt_valid`, forms the one-hot grant bus. Arbitration is fair: the last grantee gets lowest priority on the next decision.

---
 rtl/rr_arb_pkg.sv | 19 +
 rtl/rr_pick4.sv | 31 +++
 rtl/rr_grant_encoder4.sv | 100 ++++++++++
 tb/tb_rr_grant_encoder4.sv | 131 +++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-requester round-robin grant encoder.
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [IDX_W-1:0] idx_t;

  // Index that is searched k places after the pointer; wraps through 2-bit overflow.
  function automatic idx_t search_idx(input idx_t ptr, input int unsigned k);
    search_idx = ptr + idx_t'(k);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: scans ptr+1 .. ptr+4 and returns the first
// requester found. The requester at ptr itself is examined last.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  idx_t               ptr,
  input  logic [NUM_REQ-1:0] req,
  output idx_t               idx,
  output logic               found
);

  idx_t cand;

  // Walk the search order once; the first set request bit wins.
  always_comb begin
    idx   = 2'b00;
    found = 1'b0;
    cand  = 2'b00;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = search_idx(ptr, k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_grant_encoder4.sv
// Four-requester round-robin arbiter with grant hold, done-handshake release and
// a timeout that force-releases a grant after TIMEOUT cycles. Emits a registered
// grantee index plus valid flag for a downstream 2-to-4 decoder.
module rr_grant_encoder4
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  arb_state_t       state;
  idx_t             ptr;
  logic [TMR_W-1:0] timer;

  idx_t pick_ptr;
  idx_t pick_idx;
  logic pick_found;
  logic expired;
  logic release_now;
  logic force_release;

  // In GRANT the picker already looks from the current grantee, so a release
  // can re-arbitrate in the same cycle as the pointer update.
  assign pick_ptr      = (state == GRANT) ? idx_t'(gnt_idx) : ptr;
  assign expired       = (timer == TMR_LAST);
  assign release_now   = done || expired;
  assign force_release = expired && !done;

  rr_pick4 u_pick (
    .ptr   (pick_ptr),
    .req   (req),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Arbitration FSM: state, fairness pointer, grant timer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'b11;
      timer     <= '0;
      gnt_idx   <= 2'b00;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (pick_found) begin
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            timer     <= '0;
            state     <= GRANT;
          end else begin
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr     <= gnt_idx;
            timeout <= force_release;
            timer   <= '0;
            if (pick_found) begin
              gnt_idx   <= pick_idx;
              gnt_valid <= 1'b1;
              state     <= GRANT;
            end else begin
              // gnt_idx keeps the last grantee while idle.
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            timer   <= timer + TMR_W'(1);
            timeout <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
          timeout   <= 1'b0;
          timer     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_encoder4.sv
// Directed, scoreboard-based bench for rr_grant_encoder4.
module tb_rr_grant_encoder4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int tests;
  int fails;

  // expected {gnt_idx, gnt_valid, timeout}
  logic [3:0] sb[$];

  rr_grant_encoder4 #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed idx/valid/timeout=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, push expectation, compare just after posedge.
  task automatic cyc(input logic [3:0] r, input logic d, input logic [1:0] ei,
                     input logic ev, input logic et, input string tag);
    logic [3:0] exp;
    @(negedge clk);
    req  = r;
    done = d;
    sb.push_back({ei, ev, et});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = sb.pop_front();
      check(tag, {gnt_idx, gnt_valid, timeout}, exp);
    end
  endtask

  // Raise reset between edges and check the outputs clear without a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check(tag, {gnt_idx, gnt_valid, timeout}, 4'b0000);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] dec;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    #12;
    check("reset_state", {gnt_idx, gnt_valid, timeout}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Single requester 0, decoder view.
    cyc(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, "t1_grant0");
    dec = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
    check("t1_decoder", dec, 4'b0001);
    cyc(4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, "t1_release_idle");

    // All requesting, done each grant: 0,1,2,3,0 without bubble.
    async_reset("t2_reset");
    cyc(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, "t2_g0");
    cyc(4'b1111, 1'b1, 2'd1, 1'b1, 1'b0, "t2_g1");
    cyc(4'b1111, 1'b1, 2'd2, 1'b1, 1'b0, "t2_g2");
    cyc(4'b1111, 1'b1, 2'd3, 1'b1, 1'b0, "t2_g3");
    cyc(4'b1111, 1'b1, 2'd0, 1'b1, 1'b0, "t2_g0_again");
    cyc(4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, "t2_to_idle");

    // Requester 2 held, no done: 16 cycles valid, then timeout pulse with regrant.
    for (int i = 0; i < 16; i++) begin
      cyc(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, "t3_hold");
    end
    cyc(4'b0100, 1'b0, 2'd2, 1'b1, 1'b1, "t3_timeout_pulse");
    cyc(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, "t3_pulse_once");
    cyc(4'b0000, 1'b1, 2'd2, 1'b0, 1'b0, "t3_to_idle");

    // done coincides with timer expiry: normal release, no timeout.
    for (int i = 0; i < 16; i++) begin
      cyc(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, "t4_hold");
    end
    cyc(4'b0100, 1'b1, 2'd2, 1'b1, 1'b0, "t4_done_at_expiry");
    cyc(4'b0000, 1'b1, 2'd2, 1'b0, 1'b0, "t4_to_idle");

    // Grantee 1 drops req mid-grant: grant holds until done, idx stays 1.
    cyc(4'b0010, 1'b0, 2'd1, 1'b1, 1'b0, "t5_grant1");
    cyc(4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, "t5_hold_a");
    cyc(4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, "t5_hold_b");
    cyc(4'b0000, 1'b1, 2'd1, 1'b0, 1'b0, "t5_release");
    cyc(4'b0000, 1'b1, 2'd1, 1'b0, 1'b0, "t5_idle_done_ignored");

    // Async reset mid-grant, then pointer restart checks.
    cyc(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, "t6_grant0");
    async_reset("t6_async_reset");
    cyc(4'b1000, 1'b0, 2'd3, 1'b1, 1'b0, "t6_grant3");
    async_reset("t6_reset_again");
    cyc(4'b1001, 1'b0, 2'd0, 1'b1, 1'b0, "t6_ptr3_gives0");
    cyc(4'b1001, 1'b1, 2'd3, 1'b1, 1'b0, "t6_then3");
    cyc(4'b1001, 1'b1, 2'd0, 1'b1, 1'b0, "t6_then0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
